// File: rtl/redun_sq_wrapper.sv
// Iterated Montgomery squaring engine (VDF core): operand <- operand^2 * R^-1 mod MODULUS, forever.
// Optional macro REDUN_OVF_CHK_EN adds the sticky o_overflow input-range flag.
module redun_sq_wrapper #(
   parameter int unsigned DIG_BITS    = 16,
   parameter int unsigned NUM_WRDS    = 64,
   parameter logic [DIG_BITS*NUM_WRDS-1:0] MODULUS = '1,
   parameter int unsigned LOCK_CYCLES = 16
) (
   input  logic                              i_clk,
   input  logic                              i_reset,
   input  logic [NUM_WRDS*(DIG_BITS+1)-1:0]  i_sq_in,
   input  logic                              i_start,
   output logic [NUM_WRDS*(DIG_BITS+1)-1:0]  o_sq_out,
   output logic                              o_valid,
`ifdef REDUN_OVF_CHK_EN
   output logic                              o_overflow,
`endif
   output logic                              o_locked
);

   localparam int unsigned N    = DIG_BITS * NUM_WRDS;
   localparam int unsigned DW   = DIG_BITS + 1;
   // Accumulator invariant t < B + M < 2^(N+1); two spare bits keep it exact.
   localparam int unsigned TBW  = N + 2;
   localparam int unsigned TW   = N + DIG_BITS + 2;
   localparam int unsigned CNTW = $clog2(NUM_WRDS + 2);
   localparam int unsigned LCKW = $clog2(LOCK_CYCLES + 1);
`ifdef REDUN_OVF_CHK_EN
   localparam int unsigned CW   = TBW;
`else
   localparam int unsigned CW   = N;
`endif

   localparam logic [CNTW-1:0] CNT_SUB  = CNTW'(NUM_WRDS);
   localparam logic [LCKW-1:0] LOCK_END = LCKW'(LOCK_CYCLES - 1);

   // Newton iteration for the inverse mod 2^DIG_BITS, then negate.
   function automatic logic [DIG_BITS-1:0] calc_mprime(input logic [DIG_BITS-1:0] m);
      logic [DIG_BITS-1:0] inv;
      inv = DIG_BITS'(1);
      for (int unsigned i = 0; i < 7; i++) begin
         inv = inv * (DIG_BITS'(2) - m * inv);
      end
      return DIG_BITS'(0) - inv;
   endfunction

   localparam logic [DIG_BITS-1:0] M_PRIME = calc_mprime(MODULUS[DIG_BITS-1:0]);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e state_q, state_d;

   logic                              locked_q, locked_d;
   logic [LCKW-1:0]                   lock_cnt_q, lock_cnt_d;
   logic [N-1:0]                      a_q, a_d;
   logic [N-1:0]                      b_q, b_d;
   logic [TBW-1:0]                    t_q, t_d;
   logic [N-1:0]                      r_q, r_d;
   logic [CNTW-1:0]                   cnt_q, cnt_d;
   logic [NUM_WRDS*(DIG_BITS+1)-1:0]  sq_out_q, sq_out_d;
   logic                              valid_q, valid_d;

   logic                              load;
   logic                              do_iter, do_sub, do_emit;
   logic [CW-1:0]                     coll;
   logic [DIG_BITS-1:0]               a_dig;
   logic [TW-1:0]                     u_s, v_s;
   logic [DIG_BITS-1:0]               m_s;
   logic [N-1:0]                      r_sub;
   logic [NUM_WRDS*(DIG_BITS+1)-1:0]  sq_exp;

   assign load = i_start & locked_q;

   // Lock ramp after reset release
   always_comb begin
      lock_cnt_d = lock_cnt_q;
      locked_d   = locked_q;
      if (!locked_q) begin
         if (lock_cnt_q == LOCK_END) begin
            locked_d = 1'b1;
         end else begin
            lock_cnt_d = lock_cnt_q + LCKW'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         lock_cnt_q <= '0;
         locked_q   <= 1'b0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
         locked_q   <= locked_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (load) state_d = StRun;
         StRun:   state_d = StRun;
         default: state_d = StIdle;
      endcase
   end

   // Phase decode: NUM_WRDS CIOS rounds, one reduction cycle, one emit/reload cycle.
   always_comb begin
      do_iter = 1'b0;
      do_sub  = 1'b0;
      do_emit = 1'b0;
      if ((state_q == StRun) && !load) begin
         if (cnt_q < CNT_SUB) begin
            do_iter = 1'b1;
         end else if (cnt_q == CNT_SUB) begin
            do_sub = 1'b1;
         end else begin
            do_emit = 1'b1;
         end
      end
   end

   always_comb begin
      coll = '0;
      for (int unsigned k = 0; k < NUM_WRDS; k++) begin
         coll = coll + (CW'(i_sq_in[k*DW +: DW]) << (k * DIG_BITS));
      end
   end

   assign a_dig = a_q[DIG_BITS-1:0];
   assign u_s   = TW'(t_q) + TW'(a_dig) * TW'(b_q);
   assign m_s   = u_s[DIG_BITS-1:0] * M_PRIME;
   assign v_s   = u_s + TW'(m_s) * TW'(MODULUS);
   assign r_sub = (t_q >= TBW'(MODULUS)) ? N'(t_q - TBW'(MODULUS)) : N'(t_q);

   always_comb begin
      sq_exp = '0;
      for (int unsigned k = 0; k < NUM_WRDS; k++) begin
         sq_exp[k*DW +: DW] = {1'b0, r_q[k*DIG_BITS +: DIG_BITS]};
      end
   end

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      t_d      = t_q;
      r_d      = r_q;
      cnt_d    = cnt_q;
      sq_out_d = sq_out_q;
      valid_d  = 1'b0;
      if (load) begin
         a_d   = N'(coll);
         b_d   = N'(coll);
         t_d   = '0;
         cnt_d = '0;
      end else if (do_iter) begin
         t_d   = TBW'(v_s >> DIG_BITS);
         a_d   = a_q >> DIG_BITS;
         cnt_d = cnt_q + CNTW'(1);
      end else if (do_sub) begin
         r_d   = r_sub;
         cnt_d = cnt_q + CNTW'(1);
      end else if (do_emit) begin
         // Result is published and reloaded as the next operand on the same edge.
         sq_out_d = sq_exp;
         a_d      = r_q;
         b_d      = r_q;
         t_d      = '0;
         cnt_d    = '0;
         valid_d  = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         a_q      <= '0;
         b_q      <= '0;
         t_q      <= '0;
         r_q      <= '0;
         cnt_q    <= '0;
         sq_out_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         t_q      <= t_d;
         r_q      <= r_d;
         cnt_q    <= cnt_d;
         sq_out_q <= sq_out_d;
         valid_q  <= valid_d;
      end
   end

`ifdef REDUN_OVF_CHK_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (load) begin
         ovf_d = (coll >= CW'(MODULUS));
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign o_overflow = ovf_q;
`endif

   assign o_sq_out = sq_out_q;
   assign o_valid  = valid_q;
   assign o_locked = locked_q;

endmodule

// File: tb/tb_redun_sq_wrapper.sv
// Scoreboard bench for redun_sq_wrapper on the toy config (4-bit digits, 2 digits, modulus 251).
module tb_redun_sq_wrapper;

   localparam int unsigned DB     = 4;
   localparam int unsigned NW     = 2;
   localparam int unsigned LC     = 16;
   localparam int          SQ_LAT = NW + 2;
   localparam int unsigned W      = NW * (DB + 1);
   localparam int          MOD    = 251;
   localparam int          RINV   = 201;  // 256^-1 mod 251

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] sq_in = '0;
   logic [W-1:0] sq_out;
   logic         valid;
   logic         locked;
`ifdef REDUN_OVF_CHK_EN
   logic         ovf;
`endif

   redun_sq_wrapper #(
      .DIG_BITS    (DB),
      .NUM_WRDS    (NW),
      .MODULUS     (8'd251),
      .LOCK_CYCLES (LC)
   ) u_dut (
      .i_clk      (clk),
      .i_reset    (rst_n),
      .i_sq_in    (sq_in),
      .i_start    (start),
      .o_sq_out   (sq_out),
      .o_valid    (valid),
`ifdef REDUN_OVF_CHK_EN
      .o_overflow (ovf),
`endif
      .o_locked   (locked)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int val;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   total    = 0;
   int   bad      = 0;
   int   n_valid  = 0;
   int   last_val = 0;
   int   c0       = 0;

   always @(negedge clk) begin : mon
      int   v;
      logic fmt_ok;
      exp_t e;
      if (valid) begin
         n_valid++;
         v      = 0;
         fmt_ok = 1'b1;
         for (int k = 0; k < NW; k++) begin
            v += int'(sq_out[k*(DB+1) +: (DB+1)]) << (k * DB);
            if (sq_out[k*(DB+1) + DB]) fmt_ok = 1'b0;
         end
         last_val = v;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid: got value %0d at cycle %0d, required no pulse", v, cyc);
         end else begin
            e = sb.pop_front();
            if (v != e.val) begin
               bad++;
               $display("FAIL sq_value: got %0d, required %0d (cycle %0d)", v, e.val, cyc);
            end
            total++;
            if (cyc != e.cyc) begin
               bad++;
               $display("FAIL sq_timing: pulse at cycle %0d, required cycle %0d", cyc, e.cyc);
            end
         end
         total++;
         if (!fmt_ok) begin
            bad++;
            $display("FAIL digit_fmt: got word %h, required all digit carry bits zero", sq_out);
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic start_sq(input logic [W-1:0] v);
      sq_in = v;
      start = 1'b1;
      c0    = cyc;
      tick();
      start = 1'b0;
   endtask

   // Expected n-th pulse after the most recent start
   task automatic push(input int val, input int n);
      exp_t e;
      e.val = val;
      e.cyc = c0 + 1 + SQ_LAT * n;
      sb.push_back(e);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) tick();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: %0d pulses outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic wait_lock(input bit poke);
      for (int k = 1; k <= int'(LC); k++) begin
         if (poke && k == 3) begin
            sq_in = W'(10);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         chk("locked_ramp", int'(locked), (k >= int'(LC)) ? 1 : 0);
      end
      start = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int x;
      int p;
      repeat (3) tick();
      chk("rst_valid", int'(valid), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_sq_out", int'(sq_out), 0);
`ifdef REDUN_OVF_CHK_EN
      chk("rst_ovf", int'(ovf), 0);
`endif
      rst_n = 1'b1;
      wait_lock(1'b1);
      repeat (8) tick();
      chk("idle_no_valid", n_valid, 0);

      // Long stream from to_mont(2)
      start_sq(W'(10));
      push(20, 1);
      push(80, 2);
      push(25, 3);
      x = 25;
      for (int n = 4; n <= 1000; n++) begin
         x = ((x * x) % MOD) * RINV % MOD;
         push(x, n);
      end
      drain(SQ_LAT * 1000 + 20);
      p = 2;
      repeat (1000) p = (p * p) % MOD;
      chk("from_mont_final", (last_val * RINV) % MOD, p);

      // Restart in the middle of a square
      repeat (2) tick();
      start_sq(W'(20));
      push(80, 1);
      push(25, 2);
      drain(40);

      // Asynchronous reset mid-square
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", int'(valid), 0);
      chk("midrst_locked", int'(locked), 0);
      chk("midrst_sq_out", int'(sq_out), 0);
      tick();
      tick();
      rst_n = 1'b1;
      wait_lock(1'b0);
      start_sq(W'(10));
      push(20, 1);
      push(80, 2);
      drain(40);

      // Redundant input: digit0=0x10 (carry set), digit1=0x1 -> value 32
      tick();
      start_sq({5'h01, 5'h10});
      push(4, 1);
      push(204, 2);
      drain(40);

      // Redundant input: digit0=0x1A -> value 26
      tick();
      start_sq({5'h00, 5'h1A});
      push(85, 1);
      drain(40);

`ifdef REDUN_OVF_CHK_EN
      tick();
      start_sq({5'h0F, 5'h1A});
      chk("ovf_set", int'(ovf), 1);
      tick();
      start_sq(W'(10));
      chk("ovf_clear", int'(ovf), 0);
      push(20, 1);
      drain(40);
`endif

      tick();
      rst_n = 1'b0;
      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/redun_sq_wrapper.md
Name: redun_sq_wrapper

Overview:
- Iterated Montgomery squaring engine; the core of a VDF evaluator, computing x^(2^T) mod MODULUS.
- Takes one Montgomery-form operand in redundant (carry-save digit) form and squares it repeatedly: out = in*in*R^-1 mod MODULUS, with R = 2^(DIG_BITS*NUM_WRDS).
- Each result is fed back as the next operand, indefinitely.
- Provides a lock/ready indication, a per-square valid strobe and the current result.

Parameters:
- DIG_BITS, 16, payload bits per digit; each redundant digit is DIG_BITS+1 bits wide.
- NUM_WRDS, 64, number of digits; operand size N = DIG_BITS*NUM_WRDS.
- MODULUS, N-bit constant, odd modulus; MODULUS < 2^N.
- LOCK_CYCLES, 16, cycles after reset release before o_locked asserts.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset. Asynchronous, active-low.
- i_sq_in  in  NUM_WRDS*(DIG_BITS+1)  initial operand. Digit k occupies bits [k*(DIG_BITS+1) +: DIG_BITS+1]. Value = sum digit_k*2^(k*DIG_BITS).
- i_start  in  1  single-cycle strobe; loads i_sq_in and begins squaring.
- o_sq_out  out  NUM_WRDS*(DIG_BITS+1)  latest square, in redundant form.
- o_valid  out  1  one-cycle pulse when o_sq_out holds a new square.
- o_locked  out  1  engine ready; stays high until the next reset.

Behaviour:
- Reset (i_reset=0, asynchronous): o_valid=0, o_locked=0, o_sq_out=0, lock counter=0, FSM=IDLE.
- Lock: after reset deasserts, count LOCK_CYCLES clocks, then set o_locked=1.
- States: IDLE, RUN.
- IDLE -> RUN on i_start=1 while o_locked=1. Capture i_sq_in as the operand. i_start while unlocked is ignored.
- RUN: compute one Montgomery square in exactly SQ_LAT = NUM_WRDS+2 cycles. Word-serial CIOS with a carry-save accumulator is the intended microarchitecture.
- The first o_valid pulse occurs SQ_LAT cycles after the i_start cycle. Subsequent pulses occur every SQ_LAT cycles with no gaps.
- On each pulse: o_sq_out is updated and the same value becomes the next operand. o_sq_out holds between pulses.
- Output value rule: the collapsed value of o_sq_out (sum of digits with weights) must equal the canonical result in [0, MODULUS-1].
- Digit format: each digit of o_sq_out must be < 2^DIG_BITS, i.e. carry bits are zero after final normalisation.
- Input: digits may carry a set top bit. The collapsed value must be < MODULUS; otherwise the behaviour is unspecified (see the optional feature).
- i_start during RUN: abort the current square, reload from i_sq_in and restart timing. No o_valid is produced for the aborted square.
- Reset mid-RUN: immediate return to the reset state; o_locked must re-lock.
- The engine never stops on its own. The consumer counts o_valid pulses.
- MODULUS odd: m' = -MODULUS^-1 mod 2^DIG_BITS is a derived constant computed at elaboration.

Optional Feature:
- Macro: REDUN_OVF_CHK_EN.
- Defined: adds output o_overflow (1 bit, reset 0).
  - Set on an accepted i_start whose collapsed i_sq_in value is >= MODULUS.
  - Sticky until reset or the next accepted i_start with a legal input.
  - Squaring proceeds regardless.
- Undefined: no o_overflow port and no comparison logic.

Test Plan:
- Toy config DIG_BITS=4, NUM_WRDS=2, MODULUS=251 (R=256, R mod 251=5). Release reset -> o_locked=0 for LOCK_CYCLES, then 1.
- Start with i_sq_in = 10 (to_mont(2)) -> o_valid pulses at SQ_LAT=4 cycles, then every 4 cycles. Collapsed outputs are 20, 80, 25 (to_mont of 4, 16, 256 mod 251).
- Run 1000 iterations -> each output equals fe_mul_mont(prev, prev). from_mont(final) = 2^(2^1000) mod 251.
- Input in non-normalised redundant form with the same value 10 (digit0=0x1A top bit set, digit1=0x0 -> 0x10+0xA... encode 10 as digit0=10+16, digit1=-1 not allowed, so use digit0=0x0A, digit1=0x00 versus digit0=0x1A, digit1=0x0F with value 26+240=266>250, ovf case) -> ovf case sets o_overflow when REDUN_OVF_CHK_EN is defined.
- i_start before o_locked -> no o_valid. Restart mid-RUN with 20 -> next valid after 4 cycles, value 80.
- Assert reset mid-RUN -> all outputs 0 immediately. After re-lock and start with 10 -> first output 20.
